// File: rtl/draw_tile_layer_if.sv
// VGA timing bundle shared along the video chain.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hblnk;
  logic        vblnk;
  logic        hsync;
  logic        vsync;

  modport in  (input  hcount, vcount, hblnk, vblnk, hsync, vsync);
  modport out (output hcount, vcount, hblnk, vblnk, hsync, vsync);
endinterface

// File: rtl/draw_tile_layer.sv
// Tile colour stage: palette lookup, per-tile blinking, grid lines and blanking,
// with timing and colour carried through matching SUM_DELAY-deep pipelines.
module draw_tile_layer #(
  parameter int SUM_DELAY    = 2,
  parameter int TILE_W       = 3,
  parameter int TILE_SIZE    = 16,
  parameter int BLINK_FRAMES = 16,
  parameter int GRID_EN      = 1,
  parameter int RGB_B        = 12,
  parameter logic [RGB_B-1:0] GRID_COLOR         = 12'h222,
  parameter logic [RGB_B-1:0] TILE_EMPTY_COLOR   = 12'h111,
  parameter logic [RGB_B-1:0] TILE_WALL_COLOR    = 12'h00F,
  parameter logic [RGB_B-1:0] TILE_SNAKE1_COLOR  = 12'h0F0,
  parameter logic [RGB_B-1:0] TILE_SNAKE2_COLOR  = 12'hF00,
  parameter logic [RGB_B-1:0] TILE_POINT_COLOR   = 12'hFF0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [TILE_W-1:0]       act_tile,
  vga_if.in                       vga_in,
  vga_if.out                      vga_out,
  output logic [RGB_B-1:0]        rgb_o,
  input  logic                    pal_we,
  input  logic [TILE_W-1:0]       pal_addr,
  input  logic [RGB_B-1:0]        pal_data,
  input  logic [(1<<TILE_W)-1:0]  blink_mask,
  output logic                    blink_phase
);
  localparam int NTILES = 1 << TILE_W;
  localparam int CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [10:0] TMASK = 11'(TILE_SIZE - 1);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hblnk;
    logic        vblnk;
    logic        hsync;
    logic        vsync;
  } tim_t;

  typedef struct packed {
    tim_t             tim;
    logic [RGB_B-1:0] rgb;
  } pix_t;

  logic [NTILES-1:0][RGB_B-1:0] pal_q, pal_d;
  logic [CNT_W-1:0]             frm_cnt_q, frm_cnt_d;
  logic                         vs_prev_q, vs_prev_d;
  logic                         blink_q, blink_d;
  pix_t [SUM_DELAY-1:0]         pipe_q, pipe_d;
  logic [RGB_B-1:0]             rgb_sel;

  function automatic logic [NTILES-1:0][RGB_B-1:0] pal_default();
    logic [NTILES-1:0][RGB_B-1:0] p;
    for (int i = 0; i < NTILES; i++) p[i] = TILE_EMPTY_COLOR;
    p[1] = TILE_WALL_COLOR;
    p[2] = TILE_SNAKE1_COLOR;
    p[3] = TILE_SNAKE2_COLOR;
    p[4] = TILE_POINT_COLOR;
    return p;
  endfunction

  always_comb begin
    pal_d = pal_q;
    if (pal_we) pal_d[pal_addr] = pal_data;
  end

  // Blink half-period counts vsync rising edges; phase flips as the count wraps.
  always_comb begin
    vs_prev_d = vga_in.vsync;
    frm_cnt_d = frm_cnt_q;
    blink_d   = blink_q;
    if (vga_in.vsync && !vs_prev_q) begin
      if (frm_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        frm_cnt_d = '0;
        blink_d   = ~blink_q;
      end else begin
        frm_cnt_d = frm_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    rgb_sel = pal_q[act_tile];
    if (blink_q && blink_mask[act_tile]) rgb_sel = pal_q[0];
    if ((GRID_EN != 0) && (((vga_in.hcount & TMASK) == '0) || ((vga_in.vcount & TMASK) == '0)))
      rgb_sel = GRID_COLOR;
    if (vga_in.hblnk || vga_in.vblnk) rgb_sel = '0;
  end

  always_comb begin
    pipe_d[0].tim.hcount = vga_in.hcount;
    pipe_d[0].tim.vcount = vga_in.vcount;
    pipe_d[0].tim.hblnk  = vga_in.hblnk;
    pipe_d[0].tim.vblnk  = vga_in.vblnk;
    pipe_d[0].tim.hsync  = vga_in.hsync;
    pipe_d[0].tim.vsync  = vga_in.vsync;
    pipe_d[0].rgb        = rgb_sel;
    for (int i = 1; i < SUM_DELAY; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pal_q     <= pal_default();
      frm_cnt_q <= '0;
      vs_prev_q <= 1'b0;
      blink_q   <= 1'b0;
      pipe_q    <= '0;
    end else begin
      pal_q     <= pal_d;
      frm_cnt_q <= frm_cnt_d;
      vs_prev_q <= vs_prev_d;
      blink_q   <= blink_d;
      pipe_q    <= pipe_d;
    end
  end

  assign rgb_o          = pipe_q[SUM_DELAY-1].rgb;
  assign vga_out.hcount = pipe_q[SUM_DELAY-1].tim.hcount;
  assign vga_out.vcount = pipe_q[SUM_DELAY-1].tim.vcount;
  assign vga_out.hblnk  = pipe_q[SUM_DELAY-1].tim.hblnk;
  assign vga_out.vblnk  = pipe_q[SUM_DELAY-1].tim.vblnk;
  assign vga_out.hsync  = pipe_q[SUM_DELAY-1].tim.hsync;
  assign vga_out.vsync  = pipe_q[SUM_DELAY-1].tim.vsync;
  assign blink_phase    = blink_q;
endmodule

// File: tb/tb_draw_tile_layer.sv
// Scoreboard bench: three instances (latency 2 / 5 / 1, grid off on the 5-deep one)
// share one stimulus stream; each expected pixel is queued with its due cycle.
module tb_draw_tile_layer;
  localparam logic [11:0] EMPTY = 12'h111, WALL = 12'h00F, SN1 = 12'h0F0,
                          SN2 = 12'hF00, POINT = 12'hFF0, GRID = 12'h222;

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic [25:0] tim;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0]  act_tile = '0;
  logic        pal_we = 1'b0;
  logic [2:0]  pal_addr = '0;
  logic [11:0] pal_data = '0;
  logic [7:0]  blink_mask = '0;
  logic [11:0] rgb_a, rgb_b, rgb_c;
  logic        bp_a, bp_b, bp_c;
  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  exp_t q[3][$];
  logic [11:0] act_rgb[3];
  logic [25:0] act_tim[3];
  logic [11:0] dpal[8];

  vga_if vin();
  vga_if va();
  vga_if vb();
  vga_if vc();

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  draw_tile_layer #(.SUM_DELAY(2), .BLINK_FRAMES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .act_tile(act_tile), .vga_in(vin), .vga_out(va),
    .rgb_o(rgb_a), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .blink_mask(blink_mask), .blink_phase(bp_a));
  draw_tile_layer #(.SUM_DELAY(5), .GRID_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .act_tile(act_tile), .vga_in(vin), .vga_out(vb),
    .rgb_o(rgb_b), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .blink_mask(blink_mask), .blink_phase(bp_b));
  draw_tile_layer #(.SUM_DELAY(1), .BLINK_FRAMES(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .act_tile(act_tile), .vga_in(vin), .vga_out(vc),
    .rgb_o(rgb_c), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .blink_mask(blink_mask), .blink_phase(bp_c));

  assign act_rgb[0] = rgb_a;
  assign act_rgb[1] = rgb_b;
  assign act_rgb[2] = rgb_c;
  assign act_tim[0] = {va.hcount, va.vcount, va.hblnk, va.vblnk, va.hsync, va.vsync};
  assign act_tim[1] = {vb.hcount, vb.vcount, vb.hblnk, vb.vblnk, vb.hsync, vb.vsync};
  assign act_tim[2] = {vc.hcount, vc.vcount, vc.hblnk, vc.vblnk, vc.hsync, vc.vsync};

  // Monitor: every entry due this cycle is popped and compared against the outputs.
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      while (q[k].size() > 0 && q[k][0].due <= cyc) begin
        e = q[k].pop_front();
        n_vec++;
        if (e.due != cyc || act_rgb[k] !== e.rgb || act_tim[k] !== e.tim) begin
          n_bad++;
          $display("FAIL pix dut%0d cyc=%0d due=%0d rgb got %h exp %h tim got %h exp %h",
                   k, cyc, e.due, act_rgb[k], e.rgb, act_tim[k], e.tim);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [25:0] got, input logic [25:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  // Drive one pixel; ea = expected colour with grid on, eb = with grid off.
  task automatic drive(input logic [2:0] t, input int h, input int v, input logic hb,
                       input logic vbk, input logic vs, input logic [11:0] ea,
                       input logic [11:0] eb);
    exp_t e;
    @(posedge clk); #1;
    pal_we      = 1'b0;
    act_tile    = t;
    vin.hcount  = 11'(h);
    vin.vcount  = 11'(v);
    vin.hblnk   = hb;
    vin.vblnk   = vbk;
    vin.hsync   = vin.hcount[3];
    vin.vsync   = vs;
    e.tim = {vin.hcount, vin.vcount, hb, vbk, vin.hcount[3], vs};
    e.rgb = ea; e.due = cyc + 2; q[0].push_back(e);
    e.rgb = eb; e.due = cyc + 5; q[1].push_back(e);
    e.rgb = ea; e.due = cyc + 1; q[2].push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q[0].size() + q[1].size() + q[2].size()) > 0; i++)
      @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ((q[0].size() + q[1].size() + q[2].size()) != 0) begin
      n_bad++;
      $display("FAIL drain pending %0d exp 0", q[0].size() + q[1].size() + q[2].size());
    end
  endtask

  initial begin
    dpal = '{EMPTY, WALL, SN1, SN2, POINT, EMPTY, EMPTY, EMPTY};
    vin.hcount = '0; vin.vcount = '0; vin.hblnk = 1'b0;
    vin.vblnk = 1'b0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rgb_a", 26'(rgb_a), 26'h0);
    chk("rst_tim_a", act_tim[0], 26'h0);
    chk("rst_rgb_b", 26'(rgb_b), 26'h0);
    chk("rst_phase", 26'(bp_a), 26'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Defaults, grid, blanking priority
    drive(3'd4, 5, 5, 1'b0, 1'b0, 1'b0, POINT, POINT);
    drive(3'd1, 32, 7, 1'b0, 1'b0, 1'b0, GRID, WALL);
    drive(3'd1, 32, 7, 1'b1, 1'b0, 1'b0, 12'h000, 12'h000);
    drive(3'd3, 0, 5, 1'b0, 1'b0, 1'b0, GRID, SN2);
    drive(3'd2, 6, 16, 1'b0, 1'b0, 1'b0, GRID, SN1);
    drive(3'd7, 6, 6, 1'b0, 1'b0, 1'b0, EMPTY, EMPTY);
    drive(3'd0, 6, 6, 1'b0, 1'b1, 1'b0, 12'h000, 12'h000);

    // hcount ramp across tile boundaries
    for (int h = 100; h < 140; h++)
      drive(3'(h % 8), h, 3, 1'b0, 1'b0, 1'b0, (h % 16 == 0) ? GRID : dpal[h % 8], dpal[h % 8]);

    // Palette write: the writing cycle still sees the old colour
    drive(3'd2, 6, 6, 1'b0, 1'b0, 1'b0, SN1, SN1);
    pal_we = 1'b1; pal_addr = 3'd2; pal_data = 12'hABC;
    drive(3'd2, 7, 6, 1'b0, 1'b0, 1'b0, 12'hABC, 12'hABC);

    // Blink: BLINK_FRAMES=2 on A/C, tile 4 blinks, tile 3 does not
    blink_mask = 8'b0001_0000;
    drive(3'd4, 6, 6, 1'b0, 1'b0, 1'b1, POINT, POINT);
    drive(3'd4, 6, 6, 1'b0, 1'b0, 1'b0, POINT, POINT);
    drive(3'd4, 6, 6, 1'b0, 1'b0, 1'b1, POINT, POINT);
    drive(3'd4, 6, 6, 1'b0, 1'b0, 1'b0, EMPTY, POINT);
    chk("phase_f2", 26'(bp_a), 26'h1);
    drive(3'd3, 6, 6, 1'b0, 1'b0, 1'b0, SN2, SN2);
    drive(3'd4, 6, 6, 1'b0, 1'b0, 1'b1, EMPTY, POINT);
    drive(3'd4, 6, 6, 1'b0, 1'b0, 1'b0, EMPTY, POINT);
    drive(3'd4, 6, 6, 1'b0, 1'b0, 1'b1, EMPTY, POINT);
    drive(3'd4, 6, 6, 1'b0, 1'b0, 1'b0, POINT, POINT);
    chk("phase_f4", 26'(bp_a), 26'h0);
    drive(3'd4, 6, 6, 1'b0, 1'b0, 1'b1, POINT, POINT);
    drive(3'd4, 6, 6, 1'b0, 1'b0, 1'b0, POINT, POINT);
    drive(3'd4, 6, 6, 1'b0, 1'b0, 1'b1, POINT, POINT);
    drive(3'd4, 6, 6, 1'b0, 1'b0, 1'b0, EMPTY, POINT);
    drain();
    chk("phase_pre_rst", 26'(bp_a), 26'h1);

    // Asynchronous reset mid-cycle
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_rgb_a", 26'(rgb_a), 26'h0);
    chk("mid_rst_tim_a", act_tim[0], 26'h0);
    chk("mid_rst_rgb_b", 26'(rgb_b), 26'h0);
    chk("mid_rst_rgb_c", 26'(rgb_c), 26'h0);
    chk("mid_rst_phase", 26'(bp_a), 26'h0);
    vin.vsync = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    drive(3'd2, 6, 6, 1'b0, 1'b0, 1'b0, SN1, SN1);
    drive(3'd4, 9, 6, 1'b0, 1'b0, 1'b0, POINT, POINT);
    chk("phase_post_rst", 26'(bp_a), 26'h0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
